lsu: RTL and testbench

- Load/store unit directly downstream of the ALU in the 06_cpu datapath.
- Takes the ALU sum (rs1 + imm) as the effective address, plus rs2 store data and funct3, and performs one memory transaction over a req/ack data bus.
- Returns sign/zero-extended load data for writeback, or an error code.
- Multi-cycle; stalls the pipeline through o_ready.

---
 rtl/lsu.sv | 199 +++++++++++++++++++
 tb/tb_lsu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one memory transaction per accepted request over a req/ack bus,
// returning extended load data or an error code with a single-cycle done pulse.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    // state | meaning
    // IDLE  | ready for a request
    // REQ   | bus request outstanding, waiting for ack or timeout
    // DONE  | o_done pulse with o_rdata/o_err valid
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_F3    = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    state_t         state_q, state_d;
    logic           we_q;
    logic [2:0]     f3_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     err_q, err_d;
    logic           done_q, done_d;

    logic           illegal;
    logic           misaligned;
    logic           accept;
    logic           in_req;
    logic [7:0]     byte_v;
    logic [15:0]    half_v;
    logic [31:0]    load_ext;

    assign accept = (state_q == IDLE) && i_valid;
    assign in_req = (state_q == REQ);

    always_comb begin
        illegal = 1'b0;
        if (i_we)
            illegal = (i_funct3 >= 3'd3);
        else
            illegal = (i_funct3 == 3'd3) || (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
        misaligned = ((i_funct3[1:0] == 2'd1) && i_addr[0])
                  || ((i_funct3[1:0] == 2'd2) && (i_addr[1:0] != 2'b00));
    end

    always_comb begin
        byte_v = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_v = i_mem_rdata[7:0];
            2'd1:    byte_v = i_mem_rdata[15:8];
            2'd2:    byte_v = i_mem_rdata[23:16];
            default: byte_v = i_mem_rdata[31:24];
        endcase
        half_v = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        load_ext = 32'h0;
        case (f3_q)
            3'd0:    load_ext = {{24{byte_v[7]}}, byte_v};
            3'd1:    load_ext = {{16{half_v[15]}}, half_v};
            3'd2:    load_ext = i_mem_rdata;
            3'd4:    load_ext = {24'h0, byte_v};
            3'd5:    load_ext = {16'h0, half_v};
            default: load_ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    cnt_d = '0;
                    if (illegal) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = ERR_F3;
                        rdata_d = 32'h0;
                    end else if (misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = ERR_ALIGN;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // an ack on the terminal timeout cycle still completes normally
                if (i_mem_ack) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                    rdata_d = we_q ? 32'h0 : load_ext;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = ERR_TMO;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= i_we;
            f3_q    <= i_funct3;
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
        end
    end

    // bus outputs come straight from the latched request, so they stay stable through REQ
    always_comb begin
        o_mem_be    = 4'b0000;
        o_mem_wdata = 32'h0;
        if (in_req) begin
            case (f3_q[1:0])
                2'd0:    o_mem_be = 4'b0001 << addr_q[1:0];
                2'd1:    o_mem_be = 4'b0011 << addr_q[1:0];
                default: o_mem_be = 4'b1111;
            endcase
            if (we_q) begin
                case (f3_q[1:0])
                    2'd0:    o_mem_wdata = {4{wdata_q[7:0]}};
                    2'd1:    o_mem_wdata = {2{wdata_q[15:0]}};
                    default: o_mem_wdata = wdata_q;
                endcase
            end
        end
    end

    assign o_mem_req  = in_req;
    assign o_mem_we   = in_req & we_q;
    assign o_mem_addr = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign o_ready    = (state_q == IDLE);
    assign o_done     = done_q;
    assign o_rdata    = rdata_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads/stores, alignment and funct3 errors, bus timeout,
// held requests and mid-transaction reset, with hand-computed expectations.
module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_done;
    logic [31:0] o_rdata;
    logic [1:0]  o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    lsu #(.TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        i_valid  = 1'b1;
        i_we     = we;
        i_funct3 = f3;
        i_addr   = addr;
        i_wdata  = wdata;
    endtask

    // issue a request, check the bus for waits+1 cycles, ack on the last one, land in DONE
    task automatic bus_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic hold, input int waits, input logic [31:0] ack_data,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata);
        drive_req(we, f3, addr, wdata);
        step();
        if (!hold) i_valid = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            chk({tag, " req"},   {31'h0, o_mem_req}, 32'h1);
            chk({tag, " addr"},  o_mem_addr, {addr[31:2], 2'b00});
            chk({tag, " be"},    {28'h0, o_mem_be}, {28'h0, exp_be});
            chk({tag, " we"},    {31'h0, o_mem_we}, {31'h0, we});
            chk({tag, " wdata"}, o_mem_wdata, exp_wdata);
            chk({tag, " ready"}, {31'h0, o_ready}, 32'h0);
            chk({tag, " nodone"}, {31'h0, o_done}, 32'h0);
            if (i == waits) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = ack_data;
            end
            step();
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'h0;
        end
        chk({tag, " done"},  {31'h0, o_done}, 32'h1);
        chk({tag, " rdata"}, o_rdata, exp_rdata);
        chk({tag, " err"},   {30'h0, o_err}, 32'h0);
        chk({tag, " reqoff"}, {31'h0, o_mem_req}, 32'h0);
    endtask

    task automatic err_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exp_err);
        drive_req(we, f3, addr, 32'hFFFF_FFFF);
        step();
        i_valid = 1'b0;
        chk({tag, " done"},  {31'h0, o_done}, 32'h1);
        chk({tag, " err"},   {30'h0, o_err}, {30'h0, exp_err});
        chk({tag, " rdata"}, o_rdata, 32'h0);
        chk({tag, " noreq"}, {31'h0, o_mem_req}, 32'h0);
        step();
        chk({tag, " pulse"}, {31'h0, o_done}, 32'h0);
        chk({tag, " ready"}, {31'h0, o_ready}, 32'h1);
        chk({tag, " noreq2"}, {31'h0, o_mem_req}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int req_cycles;
        int budget;

        i_rst = 1'b1;
        i_valid = 1'b0;
        i_we = 1'b0;
        i_funct3 = 3'd0;
        i_addr = 32'h0;
        i_wdata = 32'h0;
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'h0;
        step();
        step();
        i_rst = 1'b0;
        chk("rst ready", {31'h0, o_ready}, 32'h1);
        chk("rst done",  {31'h0, o_done}, 32'h0);
        chk("rst rdata", o_rdata, 32'h0);
        chk("rst err",   {30'h0, o_err}, 32'h0);
        chk("rst req",   {31'h0, o_mem_req}, 32'h0);
        chk("rst we",    {31'h0, o_mem_we}, 32'h0);
        chk("rst addr",  o_mem_addr, 32'h0);
        chk("rst be",    {28'h0, o_mem_be}, 32'h0);
        chk("rst wdata", o_mem_wdata, 32'h0);

        // LB, zero-wait ack: done one cycle after the REQ cycle
        bus_txn("lb", 1'b0, 3'd0, 32'h0000_1003, 32'h0, 1'b0, 0, 32'h8011_2233,
                4'b1000, 32'h0, 32'hFFFF_FF80);
        step();
        chk("lb pulse", {31'h0, o_done}, 32'h0);
        chk("lb ready", {31'h0, o_ready}, 32'h1);
        chk("lb hold",  o_rdata, 32'hFFFF_FF80);

        bus_txn("lbu", 1'b0, 3'd4, 32'h0000_1003, 32'h0, 1'b0, 0, 32'h8011_2233,
                4'b1000, 32'h0, 32'h0000_0080);
        step();

        bus_txn("lh", 1'b0, 3'd1, 32'h0000_1002, 32'h0, 1'b0, 1, 32'h8001_7FFF,
                4'b1100, 32'h0, 32'hFFFF_8001);
        step();

        bus_txn("lw", 1'b0, 3'd2, 32'h0000_1004, 32'h0, 1'b0, 0, 32'h1357_9BDF,
                4'b1111, 32'h0, 32'h1357_9BDF);
        step();

        bus_txn("sh", 1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 0, 32'hFFFF_FFFF,
                4'b1100, 32'hABCD_ABCD, 32'h0);
        step();

        bus_txn("sb", 1'b1, 3'd0, 32'h0000_2001, 32'h1234_56A5, 1'b0, 0, 32'h5555_5555,
                4'b0010, 32'hA5A5_A5A5, 32'h0);
        step();

        bus_txn("sw", 1'b1, 3'd2, 32'h0000_2008, 32'hDEAD_BEEF, 1'b0, 0, 32'h0,
                4'b1111, 32'hDEAD_BEEF, 32'h0);
        step();

        err_txn("lw mis",   1'b0, 3'd2, 32'h0000_1001, 2'd1);
        err_txn("lh mis",   1'b0, 3'd5, 32'h0000_1003, 2'd1);
        err_txn("ld f3",    1'b0, 3'd3, 32'h0000_1001, 2'd2);
        err_txn("ld f3=6",  1'b0, 3'd6, 32'h0000_1000, 2'd2);
        err_txn("st f3=4",  1'b1, 3'd4, 32'h0000_1000, 2'd2);
        err_txn("sw mis",   1'b1, 3'd2, 32'h0000_1002, 2'd1);

        // timeout: LW never acked
        drive_req(1'b0, 3'd2, 32'h0000_3000, 32'h0);
        step();
        i_valid = 1'b0;
        req_cycles = 0;
        budget = 0;
        while (!o_done && budget < 20) begin
            if (o_mem_req) req_cycles++;
            budget++;
            step();
        end
        chk("tmo reached", {31'h0, o_done}, 32'h1);
        chk("tmo req cycles", req_cycles, 32'd4);
        chk("tmo err",   {30'h0, o_err}, 32'h3);
        chk("tmo rdata", o_rdata, 32'h0);
        chk("tmo reqoff", {31'h0, o_mem_req}, 32'h0);
        step();
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h1111_1111;
        step();
        i_mem_ack = 1'b0;
        chk("stray done",  {31'h0, o_done}, 32'h0);
        chk("stray ready", {31'h0, o_ready}, 32'h1);
        chk("stray err",   {30'h0, o_err}, 32'h3);
        bus_txn("post tmo", 1'b0, 3'd2, 32'h0000_3004, 32'h0, 1'b0, 0, 32'hCAFE_F00D,
                4'b1111, 32'h0, 32'hCAFE_F00D);
        step();

        // LHU with 3 wait cycles and i_valid held throughout
        bus_txn("lhu", 1'b0, 3'd5, 32'h0000_0002, 32'h0, 1'b1, 3, 32'hBEEF_0000,
                4'b1100, 32'h0, 32'h0000_BEEF);
        chk("held valid busy", {31'h0, o_ready}, 32'h0);
        step();
        chk("held ready", {31'h0, o_ready}, 32'h1);
        chk("held noreq", {31'h0, o_mem_req}, 32'h0);
        step();
        i_valid = 1'b0;
        chk("held 2nd req",   {31'h0, o_mem_req}, 32'h1);
        chk("held 2nd ready", {31'h0, o_ready}, 32'h0);
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h7FFF_0000;
        step();
        i_mem_ack = 1'b0;
        chk("held 2nd done",  {31'h0, o_done}, 32'h1);
        chk("held 2nd rdata", o_rdata, 32'h0000_7FFF);
        step();

        // reset during the second REQ cycle
        drive_req(1'b0, 3'd2, 32'h0000_4000, 32'h0);
        step();
        i_valid = 1'b0;
        chk("rst-req c1", {31'h0, o_mem_req}, 32'h1);
        step();
        chk("rst-req c2", {31'h0, o_mem_req}, 32'h1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("mid rst req",   {31'h0, o_mem_req}, 32'h0);
        chk("mid rst ready", {31'h0, o_ready}, 32'h1);
        chk("mid rst done",  {31'h0, o_done}, 32'h0);
        chk("mid rst rdata", o_rdata, 32'h0);
        chk("mid rst err",   {30'h0, o_err}, 32'h0);
        chk("mid rst addr",  o_mem_addr, 32'h0);
        chk("mid rst be",    {28'h0, o_mem_be}, 32'h0);
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h2222_2222;
        step();
        i_mem_ack = 1'b0;
        chk("late ack done",  {31'h0, o_done}, 32'h0);
        chk("late ack rdata", o_rdata, 32'h0);
        step();
        chk("late ack done2", {31'h0, o_done}, 32'h0);
        chk("late ack ready", {31'h0, o_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
